// File: rtl/fpu_ftoi.sv
// Two-stage IEEE-754 single to signed int32 converter, round to nearest with ties away from zero.
// Stage 1 registers the decoded operand; stage 2 aligns, rounds, saturates and drives the writeback bundle.
module fpu_ftoi #(
    parameter logic [31:0] NAN_RESULT = 32'h7FFF_FFFF,
    parameter logic [31:0] POS_SAT    = 32'h7FFF_FFFF,
    parameter logic [31:0] NEG_SAT    = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        interlock,
    input  logic [31:0] srca,
    input  logic [4:0]  rt,
    input  logic        rt_flag,
    output logic [31:0] tdata,
    output logic [4:0]  rt_to_the_next,
    output logic        rt_flag_to_the_next
);

    logic [7:0]  in_exp;
    logic [22:0] in_frac;

    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [23:0] s1_mant;
    logic        s1_zero;
    logic        s1_nan;
    logic        s1_inf;
    logic        s1_big;
    logic [4:0]  s1_rt;
    logic        s1_flag;

    logic [7:0]  shamt;
    logic [31:0] scaled;
    logic [32:0] mag;
    logic [31:0] result;

    assign in_exp  = srca[30:23];
    assign in_frac = srca[22:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_mant <= '0;
            s1_zero <= 1'b0;
            s1_nan  <= 1'b0;
            s1_inf  <= 1'b0;
            s1_big  <= 1'b0;
            s1_rt   <= '0;
            s1_flag <= 1'b0;
        end else if (!interlock) begin
            s1_sign <= srca[31];
            s1_exp  <= in_exp;
            s1_mant <= {in_exp != 8'd0, in_frac};
            s1_zero <= in_exp == 8'd0;
            s1_nan  <= (in_exp == 8'hFF) && (in_frac != 23'd0);
            s1_inf  <= (in_exp == 8'hFF) && (in_frac == 23'd0);
            s1_big  <= in_exp >= 8'd158;
            s1_rt   <= rt;
            s1_flag <= rt_flag;
        end
    end

    // scaled = m * 2^(e-149): the integer part plus one fraction bit, which is the rounding bit.
    always_comb begin
        shamt  = 8'd157 - s1_exp;
        scaled = {s1_mant, 8'h00} >> shamt;
        mag    = ({1'b0, scaled} + 33'd1) >> 1;
        if (s1_zero || (s1_exp < 8'd126)) begin
            mag = '0;
        end

        if (s1_nan) begin
            result = NAN_RESULT;
        end else if (s1_inf || s1_big) begin
            result = s1_sign ? NEG_SAT : POS_SAT;
        end else if (!s1_sign && (mag > 33'h0_7FFF_FFFF)) begin
            result = POS_SAT;
        end else if (s1_sign && (mag > 33'h0_8000_0000)) begin
            result = NEG_SAT;
        end else if (s1_sign) begin
            result = ~mag[31:0] + 32'd1;
        end else begin
            result = mag[31:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tdata               <= '0;
            rt_to_the_next      <= '0;
            rt_flag_to_the_next <= 1'b0;
        end else if (!interlock) begin
            tdata               <= result;
            rt_to_the_next      <= s1_rt;
            rt_flag_to_the_next <= s1_flag;
        end
    end

endmodule

// File: tb/tb_fpu_ftoi.sv
// Scoreboard bench for fpu_ftoi: expected results are queued at issue and popped as each op emerges.
module tb_fpu_ftoi;

    logic        clk;
    logic        rstn;
    logic        interlock;
    logic [31:0] srca;
    logic [4:0]  rt;
    logic        rt_flag;
    logic [31:0] tdata;
    logic [4:0]  rt_to_the_next;
    logic        rt_flag_to_the_next;

    int checks;
    int failures;

    logic [37:0] exp_q[$];
    logic        issue;
    logic        sh_s1;
    logic        sh_out_new;

    fpu_ftoi dut (
        .clk                 (clk),
        .rstn                (rstn),
        .interlock           (interlock),
        .srca                (srca),
        .rt                  (rt),
        .rt_flag             (rt_flag),
        .tdata               (tdata),
        .rt_to_the_next      (rt_to_the_next),
        .rt_flag_to_the_next (rt_flag_to_the_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Independent integer reference: exact shift for large exponents, explicit round bit otherwise.
    function automatic logic [31:0] ref_ftoi(input logic [31:0] a);
        int     e;
        int     d;
        longint m;
        longint mag;
        longint neg;
        e = int'(a[30:23]);
        if (e == 255) begin
            if (a[22:0] != 23'd0) return 32'h7FFF_FFFF;
            return a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        m = (e == 0) ? 64'd0 : longint'({1'b1, a[22:0]});
        if (e >= 170) begin
            mag = 64'h1_0000_0000_00;
        end else if (e >= 150) begin
            mag = m << (e - 150);
        end else begin
            d = 150 - e;
            if (d > 25) mag = 0;
            else mag = (m >> d) + ((m >> (d - 1)) & 64'd1);
        end
        if (!a[31]) begin
            if (mag > 64'd2147483647) return 32'h7FFF_FFFF;
            return mag[31:0];
        end
        if (mag > 64'd2147483648) return 32'h8000_0000;
        neg = -mag;
        return neg[31:0];
    endfunction

    // Occupancy shadow only: says when an issued op should reach the outputs.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_s1      <= 1'b0;
            sh_out_new <= 1'b0;
        end else if (!interlock) begin
            sh_out_new <= sh_s1;
            sh_s1      <= issue;
        end else begin
            sh_out_new <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [37:0] e;
        if (rstn && sh_out_new) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("tdata", tdata, e[37:6]);
                chk("rt", {27'd0, rt_to_the_next}, {27'd0, e[5:1]});
                chk("rt_flag", {31'd0, rt_flag_to_the_next}, {31'd0, e[0]});
            end
        end
    end

    task automatic go_idle();
        issue     = 1'b0;
        interlock = 1'b0;
        srca      = 32'd0;
        rt        = 5'd0;
        rt_flag   = 1'b0;
    endtask

    task automatic issue_op(input logic [31:0] a, input logic [4:0] r, input logic f);
        srca      = a;
        rt        = r;
        rt_flag   = f;
        interlock = 1'b0;
        issue     = 1'b1;
        exp_q.push_back({ref_ftoi(a), r, f});
        @(posedge clk);
        #1;
        go_idle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || sh_s1 || sh_out_new) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) chk("drain_timeout", 32'd1, 32'd0);
        @(negedge clk);
        chk("idle_flag", {31'd0, rt_flag_to_the_next}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rnd_tab [10];
    logic [37:0] held;

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        go_idle();
        rnd_tab = '{32'h3FC0_0000, 32'hC020_0000, 32'h3F00_0000, 32'h3EFF_FFFF, 32'h4F00_0000,
                    32'hCF00_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h0000_0001, 32'h8000_0000};
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tdata", tdata, 32'd0);
        chk("reset_rt", {27'd0, rt_to_the_next}, 32'd0);
        chk("reset_flag", {31'd0, rt_flag_to_the_next}, 32'd0);
        #3;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Directed rounding and special-value operands, issued back to back.
        for (int i = 0; i < 10; i++) issue_op(rnd_tab[i], 5'(i + 5), 1'b1);
        drain();

        // Streaming 1.0 .. 4.0.
        issue_op(32'h3F80_0000, 5'd1, 1'b1);
        issue_op(32'h4000_0000, 5'd2, 1'b1);
        issue_op(32'h4040_0000, 5'd3, 1'b1);
        issue_op(32'h4080_0000, 5'd4, 1'b1);
        drain();

        // rt_flag=0 still computes data.
        issue_op(32'h4040_0000, 5'd7, 1'b0);
        drain();

        // Stall: 7.0 sits in stage 1 while the input wiggles.
        issue_op(32'h40E0_0000, 5'd3, 1'b1);
        interlock = 1'b1;
        held = {tdata, rt_to_the_next, rt_flag_to_the_next};
        for (int i = 0; i < 3; i++) begin
            srca    = $urandom;
            rt      = 5'($urandom);
            rt_flag = 1'b1;
            @(posedge clk);
            #1;
            chk("stall_hold", {26'd0, tdata[5:0], rt_to_the_next, rt_flag_to_the_next},
                {26'd0, held[11:0]});
            chk("stall_hold_hi", {6'd0, tdata[31:6]}, {6'd0, held[37:12]});
        end
        go_idle();
        drain();

        // Random operands with exponents around the interesting range.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = {1'($urandom), 8'($urandom_range(120, 160)), 23'($urandom)};
            issue_op(a, 5'($urandom), 1'($urandom));
        end
        drain();

        // Asynchronous reset with an op in flight.
        issue_op(32'h4120_0000, 5'd9, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_tdata", tdata, 32'd0);
        chk("arst_rt", {27'd0, rt_to_the_next}, 32'd0);
        chk("arst_flag", {31'd0, rt_flag_to_the_next}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_flag", {31'd0, rt_flag_to_the_next}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpu_ftoi.md
Name: fpu_ftoi

Overview:
Pipelined float-to-int conversion unit that consumes the ftoi operand bundle issued by the exec stage: srca, rt and rt_flag.
- One instance sits behind each exec lane (upper and lower).
- Converts an IEEE-754 single to a signed 32-bit integer, rounding to nearest with ties away from zero.
- Fixed 2-cycle latency; carries rt and rt_flag alongside the data for writeback.

Parameters:
NAN_RESULT, 32'h7FFFFFFF, value produced for any NaN input.
POS_SAT, 32'h7FFFFFFF, value produced for positive overflow and +Inf.
NEG_SAT, 32'h80000000, value produced for negative overflow and -Inf.

Ports:
clk  input  1  clock; all state updates on posedge.
rstn  input  1  asynchronous active-low reset.
interlock  input  1  pipeline hold, same signal that stalls exec.
srca  input  32  IEEE-754 single operand.
rt  input  5  destination register tag.
rt_flag  input  1  operand valid / write-enable for this op.
tdata  output  32  signed integer result.
rt_to_the_next  output  5  tag of the result.
rt_flag_to_the_next  output  1  result valid / write-enable.

Behaviour:
- Reset:
  - While rstn=0, asynchronously clear all stage registers.
  - tdata=0, rt_to_the_next=0, rt_flag_to_the_next=0, all stage-1 valid/tag/flag state=0.
  - A reset asserted mid-operation discards in-flight ops; no spurious rt_flag after release.
- Pipeline: 2 register stages; an op sampled at edge N appears on the outputs after edge N+1 when interlock=0 throughout.
- Stage 1 (S1):
  - Register sign, exponent e=srca[30:23] and mantissa m={1,srca[22:0]} (hidden bit forced to 0 when e=0).
  - Register class flags: zero/denorm (e=0), nan (e=255 and frac!=0), inf (e=255 and frac=0), big (e>=158).
  - Register rt and rt_flag.
- Stage 2 (S2):
  - Magnitude calculation:
    - If e<126, magnitude=0.
    - Else align m so the binary point sits after bit 23 of value m*2^(e-150).
    - Round to nearest, ties away from zero: add 1 when the first dropped bit is 1.
  - e=126 yields 1 (0.5 rounds to 1); 0x3EFFFFFF yields 0.
  - Negate when sign=1.
- Saturation and specials:
  - nan -> NAN_RESULT.
  - inf or big with sign=0 -> POS_SAT.
  - inf or big with sign=1 -> NEG_SAT.
  - Exactly -2^31 (0xCF000000) -> 0x80000000.
  - Any rounded magnitude > 2^31-1 for positive input -> POS_SAT. This cannot occur below e=158, but the check must exist.
- Zero and denormals: result 0 regardless of sign.
- rt_flag handling:
  - rt_flag propagates unchanged with its data.
  - Data is computed regardless of rt_flag, but downstream may use it only when rt_flag_to_the_next=1.
- Interlock:
  - While interlock=1, both stages and all outputs hold their values exactly.
  - The input is not sampled.
  - An op is neither lost nor duplicated across any stall length.
- Back-to-back ops issue every cycle with interlock=0; throughput 1 per cycle.
- No combinational path from any input to any output.

Test Plan:
- Rounding cases:
  - srca=0x3FC00000 (1.5), rt=5, rt_flag=1 -> two edges later tdata=2, rt_to_the_next=5, rt_flag_to_the_next=1.
  - srca=0xC0200000 (-2.5) -> tdata=0xFFFFFFFD (-3).
  - 0x3F000000 -> 1.
  - 0x3EFFFFFF -> 0.
- Saturation and specials:
  - 0x4F000000 -> 0x7FFFFFFF.
  - 0xCF000000 -> 0x80000000.
  - 0xFF800000 -> 0x80000000.
  - 0x7FC00000 -> 0x7FFFFFFF.
  - 0x00000001 -> 0.
  - 0x80000000 -> 0.
- Streaming: 4 consecutive ops 1.0, 2.0, 3.0, 4.0 with rt=1..4 and interlock=0 -> outputs 1, 2, 3, 4 on 4 consecutive cycles with matching rt.
- Stall:
  - Issue 7.0 (rt=3), then assert interlock for 3 cycles while srca changes.
  - Outputs hold.
  - After release, 7 appears once with rt=3; the changed srca values are never emitted.
- Reset mid-flight:
  - Issue op with rt_flag=1, then pull rstn low asynchronously between edges.
  - Outputs clear immediately.
  - After release with rt_flag=0 inputs, rt_flag_to_the_next stays 0.
- rt_flag=0 passthrough: srca=0x40400000 with rt_flag=0 -> tdata=3, rt_flag_to_the_next=0.
